grid_controller: RTL

Sequencer and arbiter for the Starflux shifter grid. Divides the 50 MHz `clock` into frame ticks, issues the one-cycle shift strobe that advances every column, and arbitrates the single per-frame column-load slot between player shots and enemy shots. It sits between the input/AI logic and the shifter grid, driving the grid's shift enable and its per-column load controls.

---
 rtl/grid_ctrl_pkg.sv | 23 ++
 rtl/frame_rate_divider.sv | 27 ++
 rtl/grid_controller.sv | 139 +++++++++++++
 3 files changed

// File: rtl/grid_ctrl_pkg.sv
// Shared constants for the Starflux grid controller: FSM encoding, grid size,
// bullet owner codes and the round-robin pick used by the arbiter.
package grid_ctrl_pkg;

  localparam int GRID_W = 160;
  localparam int GRID_H = 120;

  localparam logic OWNER_PLAYER = 1'b0;
  localparam logic OWNER_ENEMY  = 1'b1;

  localparam logic [1:0] S_WAIT  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_ARB   = 2'd2;
  localparam logic [1:0] S_LOAD  = 2'd3;

  // Returns 1 when the enemy takes the slot; on a tie the side not granted last wins.
  function automatic logic arb_pick_enemy(input logic p_ok, input logic e_ok,
                                          input logic last_grant);
    if (p_ok && e_ok) return (last_grant == OWNER_PLAYER);
    return e_ok;
  endfunction

endpackage

// File: rtl/frame_rate_divider.sv
// Free-running frame counter; o_frame_tick is decoded combinationally on the
// terminal count so the controller sees it in the same cycle.
module frame_rate_divider #(
  parameter int CLK_PER_FRAME = 833333
) (
  input  logic i_clock,
  input  logic i_reset_n,
  output logic o_frame_tick
);

  localparam int CW = (CLK_PER_FRAME > 2) ? $clog2(CLK_PER_FRAME) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_PER_FRAME - 1);

  logic [CW-1:0] r_frame_cnt;
  logic          w_last;

  assign w_last = (r_frame_cnt == LAST);

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n)  r_frame_cnt <= '0;
    else if (w_last) r_frame_cnt <= '0;
    else             r_frame_cnt <= r_frame_cnt + CW'(1);
  end

  assign o_frame_tick = w_last;

endmodule

// File: rtl/grid_controller.sv
// Frame sequencer and shot arbiter for the shifter grid: shift, then at most one
// column load per frame. Player cooldown is built only with GRID_CTRL_COOLDOWN_EN.
module grid_controller #(
  parameter int CLK_PER_FRAME   = 833333,
  parameter int COOLDOWN_FRAMES = 8,
  parameter int GRID_W          = grid_ctrl_pkg::GRID_W
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       shoot,
  input  logic       enemy_fire,
  input  logic [7:0] user_x,
  input  logic [7:0] enemy_x,
  output logic       grid_update_en,
  output logic       load_en,
  output logic [7:0] load_col,
  output logic       load_owner,
  output logic       frame_tick
);

  import grid_ctrl_pkg::*;

  localparam logic [8:0] X_LIMIT = 9'(GRID_W);

  logic       w_tick;
  logic [1:0] r_state;
  logic       r_shoot_q;
  logic       r_p_pend;
  logic       r_e_pend;
  logic       r_last_grant;
  logic       r_grid_update_en;
  logic       r_load_en;
  logic [7:0] r_load_col;
  logic       r_load_owner;

  logic w_in_arb, w_p_req, w_p_accept;
  logic w_p_ok, w_e_ok, w_pick_e;
  logic w_grant_p, w_grant_e, w_grant_any;
  logic w_p_clr, w_e_clr;

  frame_rate_divider #(
    .CLK_PER_FRAME(CLK_PER_FRAME)
  ) u_div (
    .i_clock     (clock),
    .i_reset_n   (reset_n),
    .o_frame_tick(w_tick)
  );

  assign w_in_arb = (r_state == S_ARB);
  assign w_p_req  = shoot & ~r_shoot_q;

  // Out-of-range columns are never eligible; such a request is dropped in S_ARB.
  assign w_p_ok   = r_p_pend & ({1'b0, user_x}  < X_LIMIT);
  assign w_e_ok   = r_e_pend & ({1'b0, enemy_x} < X_LIMIT);
  assign w_pick_e = arb_pick_enemy(w_p_ok, w_e_ok, r_last_grant);

  assign w_grant_e   = w_in_arb & w_pick_e;
  assign w_grant_p   = w_in_arb & w_p_ok & ~w_pick_e;
  assign w_grant_any = w_grant_p | w_grant_e;

  assign w_p_clr = w_grant_p | (w_in_arb & r_p_pend & ~w_p_ok);
  assign w_e_clr = w_grant_e | (w_in_arb & r_e_pend & ~w_e_ok);

`ifdef GRID_CTRL_COOLDOWN_EN
  localparam int CDW = (COOLDOWN_FRAMES > 0) ? $clog2(COOLDOWN_FRAMES + 1) : 1;

  logic [CDW-1:0] r_cool_cnt;

  // A grant in a tick cycle reloads rather than decrements.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)                          r_cool_cnt <= '0;
    else if (w_grant_p)                    r_cool_cnt <= CDW'(COOLDOWN_FRAMES);
    else if (w_tick && r_cool_cnt != '0)   r_cool_cnt <= r_cool_cnt - CDW'(1);
  end

  // An edge in the granting cycle itself already belongs to the cooldown window.
  assign w_p_accept = w_p_req & (r_cool_cnt == '0) & ~w_grant_p;
`else
  localparam int cooldown_unused = COOLDOWN_FRAMES;

  assign w_p_accept = w_p_req;
`endif

  // Clear-then-set keeps a request that lands in the S_ARB cycle for next frame.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_shoot_q <= 1'b0;
      r_p_pend  <= 1'b0;
      r_e_pend  <= 1'b0;
    end else begin
      r_shoot_q <= shoot;
      r_p_pend  <= (r_p_pend & ~w_p_clr) | w_p_accept;
      r_e_pend  <= (r_e_pend & ~w_e_clr) | enemy_fire;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state          <= S_WAIT;
      r_grid_update_en <= 1'b0;
      r_load_en        <= 1'b0;
      r_load_col       <= '0;
      r_load_owner     <= OWNER_PLAYER;
      r_last_grant     <= OWNER_ENEMY;
    end else begin
      r_grid_update_en <= 1'b0;
      r_load_en        <= 1'b0;
      case (r_state)
        S_WAIT: begin
          if (w_tick) begin
            r_state          <= S_SHIFT;
            r_grid_update_en <= 1'b1;
          end
        end
        S_SHIFT: r_state <= S_ARB;
        S_ARB: begin
          if (w_grant_any) begin
            r_state      <= S_LOAD;
            r_load_en    <= 1'b1;
            r_load_col   <= w_grant_e ? enemy_x : user_x;
            r_load_owner <= w_grant_e ? OWNER_ENEMY : OWNER_PLAYER;
            r_last_grant <= w_grant_e ? OWNER_ENEMY : OWNER_PLAYER;
          end else begin
            r_state <= S_WAIT;
          end
        end
        S_LOAD:  r_state <= S_WAIT;
        default: r_state <= S_WAIT;
      endcase
    end
  end

  assign grid_update_en = r_grid_update_en;
  assign load_en        = r_load_en;
  assign load_col       = r_load_col;
  assign load_owner     = r_load_owner;
  assign frame_tick     = w_tick;

endmodule
